// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches from a combinational
// instruction memory into a valid/ready slot, and halts on the exit word.
module fetch_sequencer #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] EXIT_WORD = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic             imem_en,
  output logic [31:0]      instr_out,
  output logic [31:0]      instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  // Byte-address width of the memory; MEM_WORDS is a power of two, so
  // keeping only AW bits of the PC is the modulo wrap.
  localparam int AW = $clog2(MEM_WORDS * 4);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t         state, state_d;
  logic [AW-1:0]  pc;
  logic [AW-1:0]  instr_pc_q;
  logic [AW-1:0]  redirect_target;
  logic           slot_free;
  logic           handshake;
  logic           fetch_go;
  logic           is_exit;
  logic           unused_pc_bits;

  assign redirect_target = {redirect_pc[AW-1:2], 2'b00};
  assign unused_pc_bits  = ^{redirect_pc[31:AW], redirect_pc[1:0]};

  assign slot_free = !instr_valid || instr_ready;
  assign handshake = instr_valid && instr_ready;
  assign fetch_go  = (state == FETCH) && slot_free && !redirect_valid;
  assign is_exit   = (imem_data == EXIT_WORD);

  assign imem_en   = fetch_go;
  assign imem_addr = {{(32-AW){1'b0}}, pc};
  assign instr_pc  = {{(32-AW){1'b0}}, instr_pc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (fetch_go && is_exit) state_d = HALT;
      HALT:    if (redirect_valid) state_d = FETCH;
      default: state_d = IDLE;
    endcase
    // Redirect wins everywhere except IDLE, where it only preloads the PC.
    if (redirect_valid && state != IDLE) state_d = FETCH;
  end

  // NOTE: registered state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC[AW-1:0];
      instr_out   <= '0;
      instr_pc_q  <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_target;
      if (state != IDLE) begin
        instr_valid <= 1'b0;
        halted      <= 1'b0;
      end else if (handshake) begin
        instr_valid <= 1'b0;
      end
    end else if (fetch_go && !is_exit) begin
      instr_out   <= imem_data;
      instr_pc_q  <= pc;
      instr_valid <= 1'b1;
      pc          <= pc + AW'(4);
      if (fetch_count != {CNT_W{1'b1}}) fetch_count <= fetch_count + CNT_W'(1);
    end else begin
      // Exit word: not forwarded, PC parks on it; the slot may still drain.
      if (fetch_go) halted <= 1'b1;
      if (handshake) instr_valid <= 1'b0;
    end
  end

endmodule
